// File: rtl/adpll_lock_ctrl_5bit.sv
// adpll_lock_ctrl_5bit: acquisition/lock sequencer for the 5-bit ADPLL loop (IDLE/HOLD/ACQ/TRACK/LOCKED).
// Latency: one edge from sampled error/enable to new state; gains/flags decode from the state register.
// Backpressure: none; one error sample is consumed on every clk edge.
//
// Ports:
//   clk, reset (async, active-low), enable (0 forces IDLE)
//   error/error_sign   : sign-magnitude phase error; only the magnitude is tested
//   acq_*/trk_*        : gain sets driven onto alpha_var/beta_var by state
//   lock_thresh        : in-window when error <= lock_thresh
//   unlock_thresh      : outlier when error > unlock_thresh
//   lock_count         : consecutive in-window samples per phase (0 acts as 1)
//   loop_hold, locked, lock_lost (1-cycle pulse on LOCKED->ACQ), state
module adpll_lock_ctrl_5bit #(
  parameter int unsigned HOLD_CYCLES = 8,
  parameter int unsigned LOCK_CNT_W  = 6,
  parameter int unsigned UNLOCK_FILT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [4:0]            error,
  input  logic                  error_sign,
  input  logic [4:0]            acq_alpha,
  input  logic [4:0]            acq_beta,
  input  logic [4:0]            trk_alpha,
  input  logic [4:0]            trk_beta,
  input  logic [4:0]            lock_thresh,
  input  logic [4:0]            unlock_thresh,
  input  logic [LOCK_CNT_W-1:0] lock_count,
  output logic [4:0]            alpha_var,
  output logic [4:0]            beta_var,
  output logic                  loop_hold,
  output logic                  locked,
  output logic                  lock_lost,
  output logic [2:0]            state
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_HOLD   = 3'd1;
  localparam logic [2:0] S_ACQ    = 3'd2;
  localparam logic [2:0] S_TRACK  = 3'd3;
  localparam logic [2:0] S_LOCKED = 3'd4;

  localparam int unsigned OCW = $clog2(UNLOCK_FILT + 1);
  localparam logic [7:0]  HOLD_LAST = 8'(HOLD_CYCLES - 1);
  localparam logic [OCW:0] OCNT_LIMIT = (OCW + 1)'(UNLOCK_FILT);

  logic [2:0]            state_q, state_d;
  logic [7:0]            hold_q, hold_d;
  logic [LOCK_CNT_W-1:0] wcnt_q, wcnt_d;
  logic [OCW-1:0]        ocnt_q, ocnt_d;
  logic                  lost_q, lost_d;

  // Sign only carries direction for the filter; window tests use magnitude.
  logic unused_sign;
  assign unused_sign = error_sign;

  logic                  in_win;
  logic                  outlier;
  logic [LOCK_CNT_W-1:0] n_eff;
  logic [LOCK_CNT_W:0]   wcnt_inc;
  logic [LOCK_CNT_W-1:0] wcnt_sat;
  logic                  complete;
  logic [OCW:0]          ocnt_inc;

  assign in_win   = (error <= lock_thresh);
  assign outlier  = (error > unlock_thresh);
  assign n_eff    = (lock_count == '0) ? LOCK_CNT_W'(1) : lock_count;
  assign wcnt_inc = {1'b0, wcnt_q} + 1'b1;
  assign wcnt_sat = (&wcnt_q) ? wcnt_q : wcnt_inc[LOCK_CNT_W-1:0];
  // >= rather than == so a lock_count lowered mid-phase still completes.
  assign complete = (wcnt_inc >= {1'b0, n_eff});
  assign ocnt_inc = {1'b0, ocnt_q} + 1'b1;

  // State and counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      hold_q  <= '0;
      wcnt_q  <= '0;
      ocnt_q  <= '0;
      lost_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      wcnt_q  <= wcnt_d;
      ocnt_q  <= ocnt_d;
      lost_q  <= lost_d;
    end
  end

  // Next-state and counter update.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    wcnt_d  = wcnt_q;
    ocnt_d  = ocnt_q;
    lost_d  = 1'b0;
    if (!enable) begin
      state_d = S_IDLE;
      hold_d  = '0;
      wcnt_d  = '0;
      ocnt_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_HOLD;
          hold_d  = '0;
        end
        S_HOLD: begin
          if (hold_q == HOLD_LAST) begin
            state_d = S_ACQ;
            hold_d  = '0;
          end else begin
            hold_d = hold_q + 8'd1;
          end
        end
        S_ACQ: begin
          if (!in_win) begin
            wcnt_d = '0;
          end else if (complete) begin
            state_d = S_TRACK;
            wcnt_d  = '0;
          end else begin
            wcnt_d = wcnt_sat;
          end
        end
        S_TRACK: begin
          // A single outlier aborts tracking even on a count-completing sample.
          if (outlier) begin
            state_d = S_ACQ;
            wcnt_d  = '0;
          end else if (!in_win) begin
            wcnt_d = '0;
          end else if (complete) begin
            state_d = S_LOCKED;
            wcnt_d  = '0;
          end else begin
            wcnt_d = wcnt_sat;
          end
        end
        S_LOCKED: begin
          if (!outlier) begin
            ocnt_d = '0;
          end else if (ocnt_inc == OCNT_LIMIT) begin
            state_d = S_ACQ;
            lost_d  = 1'b1;
            ocnt_d  = '0;
            wcnt_d  = '0;
          end else begin
            ocnt_d = ocnt_inc[OCW-1:0];
          end
        end
        default: begin
          state_d = S_IDLE;
          hold_d  = '0;
          wcnt_d  = '0;
          ocnt_d  = '0;
        end
      endcase
    end
  end

  // Outputs decoded purely from registered state; no error-to-gain path.
  always_comb begin
    alpha_var = acq_alpha;
    beta_var  = acq_beta;
    loop_hold = 1'b0;
    locked    = 1'b0;
    case (state_q)
      S_IDLE, S_HOLD: loop_hold = 1'b1;
      S_TRACK: begin
        alpha_var = trk_alpha;
        beta_var  = trk_beta;
      end
      S_LOCKED: begin
        alpha_var = trk_alpha;
        beta_var  = trk_beta;
        locked    = 1'b1;
      end
      S_ACQ: ;
      default: loop_hold = 1'b1;
    endcase
  end

  assign state     = state_q;
  assign lock_lost = lost_q;

endmodule

// File: tb/tb_adpll_lock_ctrl_5bit.sv
// tb_adpll_lock_ctrl_5bit: directed bench for the ADPLL lock sequencer.
// Latency: expected state per driven sample is queued, then compared 1ns after the edge.
// Backpressure: n/a.
module tb_adpll_lock_ctrl_5bit;

  localparam logic [2:0] IDLE = 3'd0, HOLD = 3'd1, ACQ = 3'd2, TRACK = 3'd3, LOCKED = 3'd4;
  localparam logic [4:0] ACQ_A = 5'h14, ACQ_B = 5'h0a, TRK_A = 5'h06, TRK_B = 5'h03;

  logic       clk;
  logic       reset;
  logic       enable;
  logic [4:0] error;
  logic       error_sign;
  logic [4:0] acq_alpha, acq_beta, trk_alpha, trk_beta;
  logic [4:0] lock_thresh, unlock_thresh;
  logic [5:0] lock_count;
  logic [4:0] alpha_var, beta_var;
  logic       loop_hold, locked, lock_lost;
  logic [2:0] state;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [2:0] st;
    logic       lost;
  } exp_t;
  exp_t sb[$];

  adpll_lock_ctrl_5bit #(
    .HOLD_CYCLES(8),
    .LOCK_CNT_W (6),
    .UNLOCK_FILT(4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .error        (error),
    .error_sign   (error_sign),
    .acq_alpha    (acq_alpha),
    .acq_beta     (acq_beta),
    .trk_alpha    (trk_alpha),
    .trk_beta     (trk_beta),
    .lock_thresh  (lock_thresh),
    .unlock_thresh(unlock_thresh),
    .lock_count   (lock_count),
    .alpha_var    (alpha_var),
    .beta_var     (beta_var),
    .loop_hold    (loop_hold),
    .locked       (locked),
    .lock_lost    (lock_lost),
    .state        (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Every output follows from the expected state plus the expected pulse.
  task automatic check_outputs(input string tag, input logic [2:0] st, input logic lost);
    chk({tag, "/state"},     8'(state),     8'(st));
    chk({tag, "/lock_lost"}, 8'(lock_lost), 8'(lost));
    chk({tag, "/loop_hold"}, 8'(loop_hold), 8'(st == IDLE || st == HOLD));
    chk({tag, "/locked"},    8'(locked),    8'(st == LOCKED));
    chk({tag, "/alpha"},     8'(alpha_var), 8'((st == TRACK || st == LOCKED) ? TRK_A : ACQ_A));
    chk({tag, "/beta"},      8'(beta_var),  8'((st == TRACK || st == LOCKED) ? TRK_B : ACQ_B));
  endtask

  // Drive one sample, queue what should be visible after the edge, then compare.
  task automatic step(input logic [4:0] err, input logic [2:0] exp_st, input logic exp_lost,
                      input string tag);
    exp_t e;
    error      = err;
    error_sign = 1'($urandom_range(0, 1));
    sb.push_back('{st: exp_st, lost: exp_lost});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check_outputs(tag, e.st, e.lost);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset         = 1'b1;
    enable        = 1'b0;
    error         = 5'd0;
    error_sign    = 1'b0;
    acq_alpha     = ACQ_A;
    acq_beta      = ACQ_B;
    trk_alpha     = TRK_A;
    trk_beta      = TRK_B;
    lock_count    = 6'd4;
    lock_thresh   = 5'd3;
    unlock_thresh = 5'd10;
    #1 reset = 1'b0;
    #2 check_outputs("reset", IDLE, 1'b0);

    // Reset holds IDLE even with enable high and the clock running.
    enable = 1'b1;
    repeat (2) @(posedge clk);
    #1 check_outputs("reset_en", IDLE, 1'b0);
    #1 reset = 1'b1;

    // Startup: HOLD on edge E through E+7, ACQ at E+8.
    for (int i = 0; i < 8; i++) step(5'd0, HOLD, 1'b0, "hold");
    step(5'd0, ACQ, 1'b0, "acq_entry");

    // Window reset: the 5 restarts the count, TRACK only on the 8th sample.
    step(5'd2, ACQ,   1'b0, "win1");
    step(5'd2, ACQ,   1'b0, "win2");
    step(5'd2, ACQ,   1'b0, "win3");
    step(5'd5, ACQ,   1'b0, "win4_out");
    step(5'd2, ACQ,   1'b0, "win5");
    step(5'd2, ACQ,   1'b0, "win6");
    step(5'd2, ACQ,   1'b0, "win7");
    step(5'd2, TRACK, 1'b0, "win8_track");

    // TRACK outlier: back to ACQ, no lock_lost.
    step(5'd2,  TRACK, 1'b0, "trk1");
    step(5'd2,  TRACK, 1'b0, "trk2");
    step(5'd15, ACQ,   1'b0, "trk_outlier");

    // Acquisition to lock from a cleared count: TRACK after 4, LOCKED after 4 more.
    for (int i = 0; i < 3; i++) step(5'd2, ACQ, 1'b0, "acq_cnt");
    step(5'd2, TRACK, 1'b0, "acq_to_track");
    for (int i = 0; i < 3; i++) step(5'd2, TRACK, 1'b0, "trk_cnt");
    step(5'd2, LOCKED, 1'b0, "trk_to_locked");

    // Unlock filter: a good sample breaks the first burst.
    step(5'd12, LOCKED, 1'b0, "unl1");
    step(5'd12, LOCKED, 1'b0, "unl2");
    step(5'd12, LOCKED, 1'b0, "unl3");
    step(5'd1,  LOCKED, 1'b0, "unl_good");
    step(5'd12, LOCKED, 1'b0, "unl5");
    step(5'd12, LOCKED, 1'b0, "unl6");
    step(5'd12, LOCKED, 1'b0, "unl7");
    step(5'd12, ACQ,    1'b1, "unl8_lost");
    step(5'd2,  ACQ,    1'b0, "lost_one_cycle");

    // Relock, then drop enable in LOCKED.
    step(5'd2, ACQ,   1'b0, "relock_a");
    step(5'd2, ACQ,   1'b0, "relock_b");
    step(5'd2, TRACK, 1'b0, "relock_track");
    for (int i = 0; i < 3; i++) step(5'd2, TRACK, 1'b0, "relock_trk");
    step(5'd2, LOCKED, 1'b0, "relock_locked");
    enable = 1'b0;
    step(5'd2, IDLE, 1'b0, "en_drop");
    step(5'd2, IDLE, 1'b0, "en_low_idle");

    // Async reset pulse in ACQ: outputs return to reset values before any edge.
    enable = 1'b1;
    for (int i = 0; i < 8; i++) step(5'd0, HOLD, 1'b0, "hold2");
    step(5'd0, ACQ, 1'b0, "acq2_entry");
    step(5'd2, ACQ, 1'b0, "acq2_cnt");
    #2 reset = 1'b0;
    #1 check_outputs("async_reset", IDLE, 1'b0);
    #1 reset = 1'b1;
    step(5'd0, HOLD, 1'b0, "post_reset_hold");

    // lock_count=0 behaves as 1; also an in-window outlier in TRACK drops to ACQ.
    lock_count = 6'd0;
    for (int i = 0; i < 7; i++) step(5'd0, HOLD, 1'b0, "hold3");
    step(5'd0, ACQ,   1'b0, "acq3_entry");
    step(5'd2, TRACK, 1'b0, "lc0_track");
    lock_thresh = 5'd20;
    step(5'd12, ACQ,  1'b0, "overlap_outlier_wins");
    lock_thresh = 5'd3;
    step(5'd2, TRACK,  1'b0, "lc0_track2");
    step(5'd2, LOCKED, 1'b0, "lc0_locked");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adpll_lock_ctrl_5bit.md
# adpll_lock_ctrl_5bit

Acquisition and lock sequencer for the 5-bit ADPLL loop. It watches the signed phase error produced after the TDC/ones-counter/subtractor stage and drives the PI-filter gains `alpha_var`/`beta_var`. Operation runs in three phases: a loop-hold reset window, a wide-gain acquisition phase, and a narrow-gain tracking phase. The block raises `locked` once the error stays inside a programmable window. It sits between the error subtractor and `pi_filter_5bit`, in the loop `clk` domain.

## Interface
- `HOLD_CYCLES`, 8: number of cycles `loop_hold` is asserted after enable; range 1..255.
- `LOCK_CNT_W`, 6: width of the consecutive-in-window counter and of `lock_count`.
- `UNLOCK_FILT`, 4: number of consecutive out-of-window samples needed to drop lock from LOCKED.
- `clk` in 1: loop clock, the same clock as `pi_filter_5bit`.
- `reset` in 1: asynchronous, active-low reset.
- `enable` in 1: run the sequencer; 0 forces IDLE.
- `error` in 5: phase-error magnitude (sign-magnitude format).
- `error_sign` in 1: error sign, 1 = negative; it does not affect window tests.
- `acq_alpha`, `acq_beta` in 5 each: gains used in IDLE/HOLD/ACQ.
- `trk_alpha`, `trk_beta` in 5 each: gains used in TRACK/LOCKED.
- `lock_thresh` in 5: an error is in-window when `error <= lock_thresh`.
- `unlock_thresh` in 5: an error is an outlier when `error > unlock_thresh`.
- `lock_count` in LOCK_CNT_W: consecutive in-window samples required per phase; 0 is treated as 1.
- `alpha_var`, `beta_var` out 5 each: gains to the PI filter.
- `loop_hold` out 1: 1 holds the filter/DCO loop in reset.
- `locked` out 1: loop is locked.
- `lock_lost` out 1: one-cycle pulse on the LOCKED->ACQ transition.
- `state` out 3: current state code.

## Operation
- State codes: IDLE=0, HOLD=1, ACQ=2, TRACK=3, LOCKED=4. Codes 5..7 are illegal and go to IDLE on the next edge.
- Priority: if `enable`=0 when sampled, the next state is IDLE from any state. This overrides all other transitions.
- IDLE: `loop_hold`=1. Goes to HOLD when `enable`=1.
- HOLD: `loop_hold`=1 for exactly HOLD_CYCLES cycles, counted by a hold counter. Then goes to ACQ.
- ACQ: acquisition gains.
  - Window counter `wcnt` increments on each in-window sample and clears to 0 on any out-of-window sample.
  - When the sample that makes `wcnt` equal to the effective `lock_count` is in-window, go to TRACK and clear `wcnt`.
- TRACK: tracking gains; same counting rule as ACQ.
  - Reaching the count goes to LOCKED.
  - Any single outlier goes to ACQ and clears `wcnt`.
  - If a sample is both an outlier and the count-completing sample, the outlier wins.
- LOCKED: tracking gains, `locked`=1.
  - Outlier counter `ocnt` counts consecutive outliers and clears on any non-outlier sample.
  - When `ocnt` reaches UNLOCK_FILT, go to ACQ, pulse `lock_lost`, and clear `wcnt` and `ocnt`.
- Counters: `wcnt` saturates at its maximum value. `wcnt` and `ocnt` are cleared on every state change.
- Outputs:
  - `alpha_var`/`beta_var` are a mux of the config inputs, selected only by the registered state. There is no other path from the error input to the gains.
  - `loop_hold`, `locked` and `state` are decoded from the state register.
  - `lock_lost` is a dedicated flop.
- `lock_thresh` greater than `unlock_thresh` is legal. In that case an in-window sample can also be an outlier, and the outlier rules take precedence.

## Timing
- Reset (`reset`=0, asynchronous):
  - State is IDLE; hold counter, `wcnt` and `ocnt` are 0.
  - `loop_hold`=1, `locked`=0, `lock_lost`=0, `state`=0.
  - `alpha_var`=`acq_alpha`, `beta_var`=`acq_beta`.
- Reset deassertion is a synchronous release: the first active edge after `reset` rises may already sample `enable`.
- Startup sequence after `enable` is sampled 1 on edge E:
  - The state is HOLD after E.
  - `loop_hold` stays 1 through edge E+HOLD_CYCLES, when the state becomes ACQ.
  - `loop_hold`=0 from E+HOLD_CYCLES onward.
- Phase latency: with N = effective `lock_count`, N consecutive in-window samples taken on edges k..k+N-1 cause the transition at edge k+N-1. The new gains appear after that edge.
- Minimum enable-to-`locked` time is HOLD_CYCLES + 2N edges.
- Lock loss: UNLOCK_FILT consecutive outliers end at edge j. After edge j, `locked`=0, `lock_lost`=1 for one cycle, and the gains switch to the acquisition set.
- Dropping `enable` in any state gives IDLE one edge later: `loop_hold`=1, `locked`=0, and no `lock_lost` pulse.
- Asserting `reset` mid-operation forces the reset values immediately, without waiting for a clock edge.

## Test plan
- Reset and startup:
  - Stimulus: hold `reset`=0, then release with `enable`=1 and HOLD_CYCLES=8.
  - Required response: reset values during reset; `loop_hold`=1 for 8 cycles after enable is sampled; then `state`=2 with acquisition gains.
- Acquisition to lock:
  - Stimulus: `lock_count`=4, `lock_thresh`=3, `unlock_thresh`=10, `error`=2 constant.
  - Required response: TRACK exactly 4 edges after ACQ entry; LOCKED 4 edges later; `alpha_var` changes from `acq_alpha` to `trk_alpha` at TRACK entry.
- Window reset:
  - Stimulus: in ACQ, errors 2,2,2,5,2,2,2,2.
  - Required response: TRACK is entered only on the 8th sample.
- Unlock filter:
  - Stimulus: in LOCKED with UNLOCK_FILT=4, errors 12,12,12,1,12,12,12,12.
  - Required response: stay LOCKED through the first burst; go to ACQ with a single-cycle `lock_lost` on the last sample.
- TRACK outlier:
  - Stimulus: in TRACK, one `error`=15.
  - Required response: ACQ on the next edge; `wcnt` cleared; no `lock_lost` pulse.
- Enable drop, reset, and `lock_count`=0:
  - Stimulus: drop `enable` in LOCKED; separately, pulse `reset` low mid-ACQ asynchronously; separately, set `lock_count`=0.
  - Required response: enable drop gives IDLE in 1 cycle with `loop_hold`=1; the reset pulse forces IDLE immediately; with `lock_count`=0, each phase advances after one in-window sample.
